// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined memory
// requests, drops responses orphaned by redirects and queues fetched words.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [3:0]  ADEF_CODE       = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inst_valid_o,
  output logic        excp_o,
  output logic [3:0]  excp_num_o
);

  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]       pc_q, pc_d;
  logic              halt_q, halt_d;
  logic [OCNT_W-1:0] outstanding_q, outstanding_d;
  logic [OCNT_W-1:0] discard_q, discard_d;
  logic [31:0]       fl_pc_q [MAX_OUTSTANDING];
  logic [31:0]       fl_pc_d [MAX_OUTSTANDING];

  logic [31:0]       iq_pc_q   [FIFO_DEPTH];
  logic [31:0]       iq_pc_d   [FIFO_DEPTH];
  logic [31:0]       iq_inst_q [FIFO_DEPTH];
  logic [31:0]       iq_inst_d [FIFO_DEPTH];
  logic              iq_excp_q [FIFO_DEPTH];
  logic              iq_excp_d [FIFO_DEPTH];
  logic [3:0]        iq_code_q [FIFO_DEPTH];
  logic [3:0]        iq_code_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [QCNT_W-1:0] iq_cnt_q, iq_cnt_d;

  logic              redirect;
  logic [31:0]       target;
  logic              aligned;
  logic              iq_empty;
  logic              iq_full;
  logic              issue;
  logic              accept;
  logic              resp;
  logic              drop_resp;
  logic              live_resp;
  logic              excp_push;
  logic              iq_push;
  logic              iq_pop;
  logic [OCNT_W-1:0] live_cnt;
  logic [31:0]       push_pc;
  logic [31:0]       push_inst;
  logic              push_excp;
  logic [3:0]        push_code;

  assign redirect = flush_i | branch_flag_i;
  assign target   = flush_i ? new_pc_i : branch_target_i;
  assign aligned  = (pc_q[1:0] == 2'b00);
  assign iq_empty = (iq_cnt_q == '0);
  assign iq_full  = (32'(iq_cnt_q) == FIFO_DEPTH);

  assign issue = !rst && !redirect && !halt_q && aligned
              && (32'(outstanding_q) < MAX_OUTSTANDING)
              && ((32'(outstanding_q) + 32'(iq_cnt_q)) < FIFO_DEPTH);
  assign accept = issue && inst_addr_ok_i;

  assign resp      = inst_data_ok_i && (outstanding_q != '0);
  assign drop_resp = resp && (redirect || (discard_q != '0));
  assign live_resp = resp && !drop_resp;

  // Misaligned PC is reported only once all older fetches have drained.
  assign excp_push = !rst && !redirect && !halt_q && !aligned
                  && (outstanding_q == '0) && !iq_full;
  assign iq_push   = live_resp || excp_push;

  assign if_inst_valid_o = !rst && !iq_empty && !redirect;
  assign iq_pop          = if_inst_valid_o && !stall_i;

  // Entries still owed to the in-flight queue; discarded ones were dropped from it.
  assign live_cnt = outstanding_q - discard_q;

  assign push_pc   = live_resp ? fl_pc_q[0]   : pc_q;
  assign push_inst = live_resp ? inst_rdata_i : '0;
  assign push_excp = !live_resp;
  assign push_code = live_resp ? 4'h0 : ADEF_CODE;

  assign inst_req_o  = issue;
  assign inst_addr_o = pc_q;

  assign if_pc_o    = (!rst && !iq_empty) ? iq_pc_q[rd_ptr_q]   : '0;
  assign if_inst_o  = (!rst && !iq_empty) ? iq_inst_q[rd_ptr_q] : '0;
  assign excp_o     = (!rst && !iq_empty) ? iq_excp_q[rd_ptr_q] : 1'b0;
  assign excp_num_o = (!rst && !iq_empty) ? iq_code_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d          = pc_q;
    halt_d        = halt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fl_pc_d       = fl_pc_q;
    iq_pc_d       = iq_pc_q;
    iq_inst_d     = iq_inst_q;
    iq_excp_d     = iq_excp_q;
    iq_code_d     = iq_code_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    iq_cnt_d      = iq_cnt_q;

    if (redirect) begin
      // In-flight queue is emptied implicitly: live_cnt becomes zero.
      pc_d          = target;
      halt_d        = 1'b0;
      outstanding_d = outstanding_q - OCNT_W'(resp);
      discard_d     = outstanding_q - OCNT_W'(resp);
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      iq_cnt_d      = '0;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (excp_push) begin
        halt_d = 1'b1;
      end
      outstanding_d = outstanding_q + OCNT_W'(accept) - OCNT_W'(resp);
      if (drop_resp) begin
        discard_d = discard_q - OCNT_W'(1);
      end

      if (live_resp) begin
        for (int unsigned i = 0; i + 1 < MAX_OUTSTANDING; i++) begin
          fl_pc_d[i] = fl_pc_q[i+1];
        end
      end
      if (accept) begin
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
          if ((32'(live_cnt) - 32'(live_resp)) == i) begin
            fl_pc_d[i] = pc_q;
          end
        end
      end

      if (iq_push) begin
        iq_pc_d[wr_ptr_q]   = push_pc;
        iq_inst_d[wr_ptr_q] = push_inst;
        iq_excp_d[wr_ptr_q] = push_excp;
        iq_code_d[wr_ptr_q] = push_code;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (iq_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      iq_cnt_d = iq_cnt_q + QCNT_W'(iq_push) - QCNT_W'(iq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      halt_q        <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      iq_cnt_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      halt_q        <= halt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      iq_cnt_q      <= iq_cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    fl_pc_q   <= fl_pc_d;
    iq_pc_q   <= iq_pc_d;
    iq_inst_q <= iq_inst_d;
    iq_excp_q <= iq_excp_d;
    iq_code_q <= iq_code_d;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle table for startup/stall, directed redirect and
// misalignment sequences, then random traffic against a program-order model.
module tb_ifetch_unit;

  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_inst_valid_o;
  logic        excp_o;
  logic [3:0]  excp_num_o;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC(BASE),
    .MAX_OUTSTANDING(MAXO),
    .FIFO_DEPTH(4),
    .ADEF_CODE(4'h1)
  ) dut (
    .clk(clk), .rst(rst),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_i(stall_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_inst_valid_o(if_inst_valid_o),
    .excp_o(excp_o), .excp_num_o(excp_num_o)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mq [$];
  logic mem_ack = 1'b0;
  logic rsp_en = 1'b0;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Memory model: in-order, data no earlier than the cycle after acceptance.
  task automatic to_sample();
    inst_addr_ok_i = mem_ack;
    if (rsp_en && mq.size() > 0) begin
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = mem_word(mq[0]);
    end else begin
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = 32'hdead_beef;
    end
    @(negedge clk);
  endtask

  task automatic advance();
    if (inst_data_ok_i) void'(mq.pop_front());
    if (inst_req_o && inst_addr_ok_i) mq.push_back(inst_addr_o);
    if (rst) mq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic fl, input logic [31:0] np,
                           input logic br, input logic [31:0] bt);
    flush_i = fl; new_pc_i = np; branch_flag_i = br; branch_target_i = bt;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; mem_ack = 1'b0; rsp_en = 1'b0;
    set_redir(1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      to_sample();
      if (k == 1) begin
        chk1("rst_req", inst_req_o, 1'b0);
        chk1("rst_valid", if_inst_valid_o, 1'b0);
        chk("rst_pc", if_pc_o, '0);
        chk("rst_inst", if_inst_o, '0);
        chk1("rst_excp", excp_o, 1'b0);
        chk("rst_num", 32'(excp_num_o), '0);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc);
    chk1({name, "_valid"}, if_inst_valid_o, 1'b1);
    chk({name, "_pc"}, if_pc_o, pc);
    chk({name, "_inst"}, if_inst_o, mem_word(pc));
    chk1({name, "_excp"}, excp_o, 1'b0);
  endtask

  logic [31:0] exp_pc, tgt, prev_addr;
  logic        exp_mis, exp_done, prev_wait, redir;
  int          pops;

  initial begin
    // Startup with 1-cycle memory, then stall held over cycles 6..11.
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h0c, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0c};
    tbl[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[7]  = '{1'b1, 1'b1, 32'h1c, 1'b1, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[14] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[15] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h1c};
    tbl[16] = '{1'b0, 1'b1, 32'h2c, 1'b1, 32'h20};
    tbl[17] = '{1'b0, 1'b1, 32'h30, 1'b1, 32'h24};

    @(posedge clk); #1;
    do_reset();
    mem_ack = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      stall_i = tbl[i].stall;
      to_sample();
      chk1("tbl_req", inst_req_o, tbl[i].req);
      if (tbl[i].req) chk("tbl_addr", inst_addr_o, BASE + tbl[i].addr);
      chk1("tbl_valid", if_inst_valid_o, tbl[i].valid);
      if (tbl[i].valid) begin
        chk("tbl_pc", if_pc_o, BASE + tbl[i].pc);
        chk("tbl_inst", if_inst_o, mem_word(BASE + tbl[i].pc));
      end
      advance();
    end
    stall_i = 1'b0;

    // Branch with two responses outstanding: both must be dropped.
    do_reset();
    mem_ack = 1'b1; rsp_en = 1'b0;
    to_sample(); chk("br_a0", inst_addr_o, BASE); chk1("br_r0", inst_req_o, 1'b1); advance();
    to_sample(); chk("br_a1", inst_addr_o, BASE + 4); chk1("br_r1", inst_req_o, 1'b1); advance();
    to_sample(); chk1("br_full_req", inst_req_o, 1'b0); advance();
    rsp_en = 1'b1;
    set_redir(1'b0, '0, 1'b1, BASE + 32'h100);
    to_sample(); chk1("br_redir_req", inst_req_o, 1'b0); chk1("br_redir_v", if_inst_valid_o, 1'b0); advance();
    set_redir(1'b0, '0, 1'b0, '0);
    to_sample(); chk1("br_drop_v", if_inst_valid_o, 1'b0); chk("br_new_addr", inst_addr_o, BASE + 32'h100); advance();
    to_sample(); chk1("br_drop2_v", if_inst_valid_o, 1'b0); advance();
    to_sample(); expect_out("br_out", BASE + 32'h100); advance();

    // Flush and branch together: flush target wins.
    do_reset();
    mem_ack = 1'b1; rsp_en = 1'b1;
    to_sample(); advance();
    set_redir(1'b1, BASE + 32'h8000, 1'b1, BASE + 32'h100);
    to_sample(); chk1("fb_req", inst_req_o, 1'b0); advance();
    set_redir(1'b0, '0, 1'b0, '0);
    to_sample(); chk1("fb_req2", inst_req_o, 1'b1); chk("fb_addr", inst_addr_o, BASE + 32'h8000); advance();
    to_sample(); advance();
    to_sample(); expect_out("fb_out", BASE + 32'h8000); advance();

    // Misaligned branch target: single exception entry, frozen until flush.
    do_reset();
    mem_ack = 1'b1; rsp_en = 1'b1;
    set_redir(1'b0, '0, 1'b1, BASE + 32'h102);
    to_sample(); advance();
    set_redir(1'b0, '0, 1'b0, '0);
    to_sample(); chk1("mis_req", inst_req_o, 1'b0); advance();
    to_sample();
    chk1("mis_valid", if_inst_valid_o, 1'b1);
    chk1("mis_excp", excp_o, 1'b1);
    chk("mis_num", 32'(excp_num_o), 32'd1);
    chk("mis_inst", if_inst_o, '0);
    chk("mis_pc", if_pc_o, BASE + 32'h102);
    advance();
    for (int k = 0; k < 4; k++) begin
      to_sample();
      chk1("mis_frozen_v", if_inst_valid_o, 1'b0);
      chk1("mis_frozen_req", inst_req_o, 1'b0);
      advance();
    end
    set_redir(1'b1, BASE + 32'h200, 1'b0, '0);
    to_sample(); advance();
    set_redir(1'b0, '0, 1'b0, '0);
    to_sample(); chk1("mis_resume_req", inst_req_o, 1'b1); chk("mis_resume_addr", inst_addr_o, BASE + 32'h200); advance();
    to_sample(); advance();
    to_sample(); expect_out("mis_out", BASE + 32'h200); advance();

    // addr_ok withheld three cycles: request and address held steady.
    do_reset();
    mem_ack = 1'b0; rsp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_sample();
      chk1("hold_req", inst_req_o, 1'b1);
      chk("hold_addr", inst_addr_o, BASE);
      advance();
    end
    mem_ack = 1'b1;
    to_sample(); chk("hold_grant", inst_addr_o, BASE); advance();
    to_sample(); chk("hold_next", inst_addr_o, BASE + 4); advance();
    to_sample(); expect_out("hold_out0", BASE); advance();
    to_sample(); expect_out("hold_out1", BASE + 4); advance();

    // Random traffic against a program-order model of the output stream.
    do_reset();
    exp_pc = BASE; exp_mis = 1'b0; exp_done = 1'b0; prev_wait = 1'b0; prev_addr = '0;
    pops = 0;
    for (int n = 0; n < 3000; n++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      mem_ack = ($urandom_range(0, 2) != 0);
      rsp_en  = ($urandom_range(0, 2) != 0);
      new_pc_i        = BASE + 32'($urandom_range(0, 255)) * 4;
      branch_target_i = BASE + 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 3) == 0) new_pc_i = new_pc_i + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) branch_target_i = branch_target_i + 32'($urandom_range(1, 3));
      flush_i = 1'b0; branch_flag_i = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: flush_i = 1'b1;
          1: branch_flag_i = 1'b1;
          default: begin flush_i = 1'b1; branch_flag_i = 1'b1; end
        endcase
      end
      to_sample();
      redir = flush_i | branch_flag_i;
      tgt   = flush_i ? new_pc_i : branch_target_i;
      chk1("rnd_outstanding", mq.size() <= MAXO, 1'b1);
      if (redir) begin
        chk1("rnd_redir_v", if_inst_valid_o, 1'b0);
        chk1("rnd_redir_req", inst_req_o, 1'b0);
      end else begin
        if (exp_mis) chk1("rnd_mis_req", inst_req_o, 1'b0);
        if (prev_wait && inst_req_o) chk("rnd_addr_hold", inst_addr_o, prev_addr);
        if (if_inst_valid_o && exp_done) chk1("rnd_after_excp_v", if_inst_valid_o, 1'b0);
        else if (if_inst_valid_o && !stall_i) begin
          pops++;
          chk("rnd_pc", if_pc_o, exp_pc);
          if (exp_mis) begin
            chk1("rnd_excp", excp_o, 1'b1);
            chk("rnd_num", 32'(excp_num_o), 32'd1);
            chk("rnd_excp_inst", if_inst_o, '0);
            exp_done = 1'b1;
          end else begin
            chk1("rnd_excp", excp_o, 1'b0);
            chk("rnd_inst", if_inst_o, mem_word(exp_pc));
            exp_pc = exp_pc + 4;
          end
        end
      end
      prev_wait = inst_req_o && !inst_addr_ok_i;
      prev_addr = inst_addr_o;
      if (redir) begin
        exp_pc   = tgt;
        exp_mis  = (tgt[1:0] != 2'b00);
        exp_done = 1'b0;
      end
      advance();
    end
    chk1("rnd_progress", pops > 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
